restador_serie: RTL and testbench
=================================

# restador_serie

Bit-serial unsigned subtractor with a start/done handshake. It computes `a - b - b_in` one bit per clock, LSB first, and registers a WIDTH-bit difference plus a borrow-out. It is the inverse-direction companion to the team's parallel ripple adder. It trades latency for a single full-subtractor cell and serves as a checkable datapath block in the arithmetic lab set.

## Interface

Parameters:
- `WIDTH`, default 4: operand and result width in bits (legal: WIDTH >= 2).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  in  1  request to begin an operation; accepted only in IDLE.
- `a`  in  WIDTH  minuend; sampled on the accepting edge only.
- `b`  in  WIDTH  subtrahend; sampled on the accepting edge only.
- `b_in`  in  1  borrow-in; sampled on the accepting edge only.
- `busy`  out  1  high while bits are being processed (state SHIFT).
- `done`  out  1  one-cycle pulse; high during the single cycle the FSM is in DONE.
- `diff`  out  WIDTH  registered result; holds its value until the next completion.
- `b_out`  out  1  registered final borrow; same update and hold rules as `diff`.

## Operation

- Arithmetic:
  - `diff = (a - b - b_in) mod 2^WIDTH`.
  - `b_out = 1` iff `a < b + b_in` (unsigned, evaluated at WIDTH+1 bits).
  - Identity that must always hold: `{b_out, diff}` satisfies `a = diff + b + b_in - b_out·2^WIDTH`.
- Per-bit cell, with `br` the internal running borrow:
  - `d = a_i ^ b_i ^ br`
  - `br' = (~a_i & b_i) | (~a_i & br) | (b_i & br)`
- Internal state:
  - Shift registers for `a` and `b` (shift right; bit 0 feeds the cell).
  - Partial-difference shift register; `d` enters at the MSB and shifts right.
  - Borrow flop `br`.
  - Bit counter, width `$clog2(WIDTH+1)`.
- FSM:
  - IDLE: `busy=0`, `done=0`. On `start=1`, load the `a`/`b` shift registers, set `br = b_in`, clear the counter, go to SHIFT.
  - SHIFT: `busy=1`. Each edge processes one bit, shifts all registers and increments the counter. On the edge that processes bit WIDTH-1, copy the full partial register into `diff`, copy `br'` into `b_out`, and go to DONE.
  - DONE: `done=1`, `busy=0`. Go to IDLE on the next edge unconditionally.
- `start` in SHIFT or DONE is ignored; no queuing. `a`, `b`, `b_in` may change freely after the accepting edge without effect.
- `diff`/`b_out` change only on the SHIFT->DONE edge. Between operations they hold the last result.
- Reset (`rst_n=0` at an edge) has priority over everything, including mid-operation:
  - FSM to IDLE.
  - `busy=0`, `done=0`, `diff=0`, `b_out=0`.
  - Shift registers, `br` and counter cleared.
  - An aborted operation never raises `done`.

## Timing

- Edge E0 samples `start=1` in IDLE. Edges E1..EWIDTH process bits 0..WIDTH-1.
- `busy` is high in cycles E0..EWIDTH-1, i.e. WIDTH cycles.
- `done` is high, and `diff`/`b_out` hold the new result, in the cycle after EWIDTH.
- Back in IDLE after EWIDTH+1.
- Latency: `start` edge to `done` cycle is WIDTH+1 edges. Minimum issue interval is WIDTH+2 cycles.
- `start` held high continuously re-triggers on the first IDLE edge after DONE.
- Reset values: `busy=0`, `done=0`, `diff=0`, `b_out=0`. Outputs take these values in the cycle after the reset edge.

## Test plan

WIDTH=4. Each case is one start pulse, then wait for `done`.

- `a=0000`, `b=0000`, `b_in=1` -> `diff=1111`, `b_out=1`. `done` 5 edges after the start edge; `busy` high exactly 4 cycles.
- `a=1111`, `b=0001`, `b_in=0` -> `diff=1110`, `b_out=0`. `a=1111`, `b=1111`, `b_in=1` -> `diff=1111`, `b_out=1`.
- `a=0000`, `b=1111`, `b_in=1` -> `diff=0000`, `b_out=1`. `a=0101`, `b=1010`, `b_in=0` -> `diff=1011`, `b_out=1`.
- Start `a=1000`, `b=0011`, `b_in=0`. Pulse `start` with other operands during cycle 2 of SHIFT. Change `a`/`b` mid-op. -> Single `done`, `diff=0101`, `b_out=0`. The second start is ignored.
- Start an operation, then drive `rst_n=0` for one edge during SHIFT. -> `busy`, `done`, `diff`, `b_out` all 0 the next cycle; no `done` pulse follows. A new start then completes normally.
- Exhaustive sweep of all a, b, b_in (512 cases), with `start` held high back-to-back -> every result matches the arithmetic identity. One `done` per WIDTH+2 cycles.

Source files
------------

// File: rtl/restador_serie.sv
// Bit-serial unsigned subtractor: a - b - b_in, one full-subtractor step per clock, LSB first.
// Start/done handshake; diff and b_out hold the last completed result.
module restador_serie #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  // state   | meaning
  // S_IDLE  | waiting for start; operands sampled on the accepting edge
  // S_SHIFT | one bit per edge through the subtractor cell
  // S_DONE  | single-cycle done pulse, result already in diff/b_out
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  // Holds the WIDTH-1 bits already produced; the last bit joins them on the final edge.
  logic [WIDTH-2:0] r_part;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_b_out;

  logic             w_d;
  logic             w_br_nxt;
  logic [WIDTH-1:0] w_cat;

  assign w_d      = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_nxt = (~r_a[0] & r_b[0]) | (~r_a[0] & r_br) | (r_b[0] & r_br);
  assign w_cat    = {w_d, r_part};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_part  <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_diff  <= '0;
      r_b_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_br    <= b_in;
            r_part  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_a    <= {1'b0, r_a[WIDTH-1:1]};
          r_b    <= {1'b0, r_b[WIDTH-1:1]};
          r_part <= w_cat[WIDTH-1:1];
          r_br   <= w_br_nxt;
          r_cnt  <= r_cnt + ONE;
          if (r_cnt == LAST) begin
            r_diff  <= w_cat;
            r_b_out <= w_br_nxt;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign diff  = r_diff;
  assign b_out = r_b_out;

endmodule

// File: tb/tb_restador_serie.sv
// Self-checking bench for restador_serie (WIDTH=4): directed cases, random ops,
// mid-op start and reset, and an exhaustive back-to-back sweep against an arithmetic model.
module tb_restador_serie;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         b_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  restador_serie #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain signed arithmetic on the integer values.
  function automatic int model_diff(input int ua, input int ub, input int ubin);
    int r;
    r = ua - ub - ubin;
    return (r < 0) ? r + (1 << W) : r;
  endfunction

  function automatic int model_bout(input int ua, input int ub, input int ubin);
    return (ua < ub + ubin) ? 1 : 0;
  endfunction

  task automatic scramble;
    a    = W'($urandom);
    b    = W'($urandom);
    b_in = 1'($urandom);
  endtask

  task automatic do_op(input int ta, input int tb, input int tbin, input bit mid, input bit hold);
    int  edges;
    int  busy_cyc;
    bit  seen;
    int  e_diff;
    int  e_bout;
    e_diff = model_diff(ta, tb, tbin);
    e_bout = model_bout(ta, tb, tbin);
    a     = W'(ta);
    b     = W'(tb);
    b_in  = 1'(tbin);
    start = 1'b1;
    tick;
    if (!hold) start = 1'b0;
    scramble;
    edges    = 1;
    busy_cyc = 0;
    seen     = 1'b0;
    while (!seen && edges <= 3 * W) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) busy_cyc++;
        if (mid && edges == 2) begin
          start = 1'b1;
          scramble;
        end else if (mid && edges == 3) begin
          start = 1'b0;
        end
        tick;
        edges++;
      end
    end
    chk("done_seen", int'(seen), 1);
    chk("latency", edges, W + 1);
    chk("busy_cycles", busy_cyc, W);
    chk("diff", int'(diff), e_diff);
    chk("b_out", int'(b_out), e_bout);
    chk("identity", int'(diff) + tb + tbin - (int'(b_out) << W), ta);
    tick;
    chk("done_pulse", int'(done), 0);
    chk("busy_after", int'(busy), 0);
    if (!hold) begin
      repeat (2) begin
        tick;
        chk("no_extra_done", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
        chk("diff_hold", int'(diff), e_diff);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    b_in  = 1'b0;
    tick;
    tick;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_diff", int'(diff), 0);
    chk("rst_bout", int'(b_out), 0);
    rst_n = 1'b1;
    tick;

    do_op(4'b0000, 4'b0000, 1, 1'b0, 1'b0);
    do_op(4'b1111, 4'b0001, 0, 1'b0, 1'b0);
    do_op(4'b1111, 4'b1111, 1, 1'b0, 1'b0);
    do_op(4'b0000, 4'b1111, 1, 1'b0, 1'b0);
    do_op(4'b0101, 4'b1010, 0, 1'b0, 1'b0);
    do_op(4'b1000, 4'b0011, 0, 1'b1, 1'b0);

    for (int i = 0; i < 30; i++)
      do_op(int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(1)),
            1'b0, 1'b0);

    // Leave a non-zero result behind so the reset check below means something.
    do_op(4'b1001, 4'b0010, 1, 1'b0, 1'b0);
    a     = 4'b0110;
    b     = 4'b0001;
    b_in  = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_diff", int'(diff), 0);
    chk("abort_bout", int'(b_out), 0);
    repeat (W + 2) begin
      tick;
      chk("abort_no_done", int'(done), 0);
    end
    do_op(4'b0110, 4'b0001, 0, 1'b0, 1'b0);

    for (int ia = 0; ia < (1 << W); ia++)
      for (int ib = 0; ib < (1 << W); ib++)
        for (int ic = 0; ic < 2; ic++)
          do_op(ia, ib, ic, 1'b0, 1'b1);
    start = 1'b0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
